// File: rtl/seg_pkg.sv
// Shared segment codes, hex glyph table and digit-index sizing for the seven-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = SEG_OFF[6:0];
    endcase
    return g;
  endfunction

  function automatic int seg_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = seg_glyph(i_nib);

endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed seven-segment scan driver with frame-synchronous data update and leading-zero blanking.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int NUM_DIG      = 6,
  parameter int CLK_DIV      = 50_000,
  parameter int BLINK_FRAMES = 250
)
(
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NUM_DIG-1:0]   data,
  input  logic [NUM_DIG-1:0]     dp_mask,
  input  logic [NUM_DIG-1:0]     blink_mask,
  input  logic                   blank_lz,
  output logic [NUM_DIG-1:0]     seg_sel,
  output logic [7:0]             seg_led,
  output logic                   frame_done
);

  localparam int IW = seg_idx_w(NUM_DIG);
  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = 4 * NUM_DIG;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIG - 1);

  logic [PW-1:0]      r_presc;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic               r_live, w_tick, w_wrap, r_frame_done;
  logic [DW-1:0]      r_pend_data, r_act_data, w_act_data;
  logic [NUM_DIG-1:0] r_pend_dp, r_act_dp, w_act_dp;
  logic [NUM_DIG-1:0] w_lz, w_sel_on, r_sel;
  logic [7:0]         r_led;
  logic [3:0]         w_nib;
  logic [6:0]         w_glyph;
  logic               w_blank, w_blink_off, w_dark;

  assign w_tick = (r_presc == PRE_MAX);
  assign w_wrap = w_tick & r_live & (r_idx == IDX_MAX);

  // The first tick after reset lights digit 0; later ticks advance the index
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      w_idx_nxt = '0;
    end else if (w_tick && r_live) begin
      w_idx_nxt = r_idx + IW'(1);
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Prescaler, digit index and frame pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_live       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_idx        <= w_idx_nxt;
      r_live       <= r_live | w_tick;
      r_frame_done <= w_wrap;
    end
  end

  // Pending/active double buffer; active only changes between frames
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
    end else begin
      if (load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp_mask;
      end
      if (w_wrap) begin
        r_act_data <= r_pend_data;
        r_act_dp   <= r_pend_dp;
      end
    end
  end

  assign w_act_data = w_wrap ? r_pend_data : r_act_data;
  assign w_act_dp   = w_wrap ? r_pend_dp   : r_act_dp;

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_FRAMES <= 1) ? 1 : $clog2(BLINK_FRAMES);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  logic [NUM_DIG-1:0] r_pend_blink, r_act_blink, w_act_blink;
  logic [BW-1:0]      r_bcnt;
  logic               r_phase, w_phase_nxt;

  assign w_act_blink = w_wrap ? r_pend_blink : r_act_blink;
  assign w_phase_nxt = (w_wrap && (r_bcnt == BLK_MAX)) ? ~r_phase : r_phase;

  // Blink mask buffering and frame-based phase counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pend_blink <= '0;
      r_act_blink  <= '0;
      r_bcnt       <= '0;
      r_phase      <= 1'b1;
    end else begin
      if (load) begin
        r_pend_blink <= blink_mask;
      end
      if (w_wrap) begin
        r_act_blink <= r_pend_blink;
        r_bcnt      <= (r_bcnt == BLK_MAX) ? '0 : r_bcnt + BW'(1);
      end
      r_phase <= w_phase_nxt;
    end
  end

  assign w_blink_off = ~w_phase_nxt & w_act_blink[w_idx_nxt];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blink_off    = 1'b0;
`endif

  // Digit i is a leading zero when it and every nibble above it are zero
  always_comb begin
    logic l_zero;
    l_zero = 1'b1;
    w_lz   = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      l_zero  = l_zero & (w_act_data[4*i +: 4] == 4'h0);
      w_lz[i] = l_zero;
    end
  end

  assign w_nib    = w_act_data[4*w_idx_nxt +: 4];
  assign w_blank  = blank_lz & (w_idx_nxt != '0) & w_lz[w_idx_nxt];
  assign w_dark   = ~en | ~(r_live | w_tick) | w_blank | w_blink_off;
  assign w_sel_on = ~(NUM_DIG'(1) << w_idx_nxt);

  seg_hex_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  // Registered digit select and segment drive
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sel <= '1;
      r_led <= SEG_OFF;
    end else if (w_dark) begin
      r_sel <= '1;
      r_led <= SEG_OFF;
    end else begin
      r_sel <= w_sel_on;
      r_led <= {~w_act_dp[w_idx_nxt], w_glyph};
    end
  end

  assign seg_sel    = r_sel;
  assign seg_led    = r_led;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Randomised scoreboard bench for seg_scan_drv; blink checks are included when SEG_BLINK_EN is defined.
module tb_seg_scan_drv;

  localparam int NUM_DIG      = 6;
  localparam int CLK_DIV      = 4;
  localparam int BLINK_FRAMES = 2;

  logic                 sys_clk, sys_rst, en, load, blank_lz;
  logic [4*NUM_DIG-1:0] data;
  logic [NUM_DIG-1:0]   dp_mask, blink_mask, seg_sel;
  logic [7:0]           seg_led;
  logic                 frame_done;

  seg_scan_drv #(
    .NUM_DIG      (NUM_DIG),
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .load       (load),
    .data       (data),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .seg_sel    (seg_sel),
    .seg_led    (seg_led),
    .frame_done (frame_done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct packed {
    logic [NUM_DIG-1:0] sel;
    logic [7:0]         led;
    logic               fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state: edges since reset release plus the two data buffers
  int                   m_n;
  logic [4*NUM_DIG-1:0] m_pend_data, m_act_data;
  logic [NUM_DIG-1:0]   m_pend_dp, m_act_dp, m_pend_bl, m_act_bl;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; 4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // k = number of ticks seen since release; digit shown is (k-1) mod NUM_DIG
  function automatic exp_t expect_out(input int k, input logic wrap);
    exp_t r;
    int d;
    logic [3:0] nib;
    logic off;
    r.fd  = wrap;
    r.sel = '1;
    r.led = 8'hFF;
    if (k > 0 && en) begin
      d   = (k - 1) % NUM_DIG;
      nib = 4'(m_act_data >> (4 * d));
      off = blank_lz && (d > 0) && ((m_act_data >> (4 * d)) == '0);
`ifdef SEG_BLINK_EN
      if (((((k - 1) / NUM_DIG) / BLINK_FRAMES) % 2) == 1 && m_act_bl[d]) off = 1'b1;
`endif
      if (!off) begin
        r.sel = ~(NUM_DIG'(1) << d);
        r.led = hex_seg(nib) & (m_act_dp[d] ? 8'h7F : 8'hFF);
      end
    end
    return r;
  endfunction

  function automatic logic next_is_wrap();
    int k;
    k = (m_n + 1) / CLK_DIV;
    return ((m_n % CLK_DIV) == CLK_DIV - 1) && (k > NUM_DIG) && (((k - 1) % NUM_DIG) == 0);
  endfunction

  // Advance the model across one clock edge and queue what the DUT must show after it
  task automatic step();
    exp_t e;
    int k;
    logic wrap;
    if (sys_rst) begin
      m_n = 0;
      m_pend_data = '0; m_act_data = '0;
      m_pend_dp = '0;   m_act_dp = '0;
      m_pend_bl = '0;   m_act_bl = '0;
      e.sel = '1; e.led = 8'hFF; e.fd = 1'b0;
    end else begin
      wrap = next_is_wrap();
      k    = (m_n + 1) / CLK_DIV;
      if (wrap) begin
        m_act_data = m_pend_data;
        m_act_dp   = m_pend_dp;
        m_act_bl   = m_pend_bl;
      end
      if (load) begin
        m_pend_data = data;
        m_pend_dp   = dp_mask;
        m_pend_bl   = blink_mask;
      end
      m_n++;
      e = expect_out(k, wrap);
    end
    @(posedge sys_clk);
    exp_q.push_back(e);
    #1;
  endtask

  function automatic logic [4*NUM_DIG-1:0] rand_data();
    logic [4*NUM_DIG-1:0] v;
    int z;
    v = {$urandom, $urandom};
    z = $urandom_range(0, NUM_DIG);
    for (int i = NUM_DIG - z; i < NUM_DIG; i++) v[4*i +: 4] = 4'h0;
    return v;
  endfunction

  // Monitor: one scoreboard entry per clock edge, compared mid-cycle
  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (seg_sel !== e.sel || seg_led !== e.led || frame_done !== e.fd) begin
        n_fail++;
        $display("FAIL scan cyc=%0d got sel=%h led=%h fd=%b expected sel=%h led=%h fd=%b",
                 cyc, seg_sel, seg_led, frame_done, e.sel, e.led, e.fd);
      end
    end
  end

  initial begin
    sys_rst    = 1'b1;
    en         = 1'b1;
    load       = 1'b0;
    data       = '0;
    dp_mask    = '0;
    blink_mask = '0;
    blank_lz   = 1'b0;
    repeat (3) step();
    sys_rst = 1'b0;
    load    = 1'b1;
    data    = 24'h123456;
    step();
    load = 1'b0;
    repeat (60) step();
    for (int c = 0; c < 4000; c++) begin
      sys_rst = ($urandom_range(0, 599) == 0);
      load    = ($urandom_range(0, 29) == 0) || (next_is_wrap() && ($urandom_range(0, 2) == 0));
      if (load) begin
        data       = rand_data();
        dp_mask    = NUM_DIG'($urandom);
        blink_mask = NUM_DIG'($urandom);
      end
      if (en ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0)) en = ~en;
      if ($urandom_range(0, 79) == 0) blank_lz = ~blank_lz;
      step();
    end
    sys_rst = 1'b0;
    load    = 1'b0;
    @(negedge sys_clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 SHALL have parameter NUM_DIG, default 6, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50_000, sys_clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 250, scan frames per blink half-period (>=1).
REQ-004 SHALL have port sys_clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port en  in  1  display enable; 0 forces all digits off.
REQ-007 SHALL have port load  in  1  strobe capturing data/dp_mask/blink_mask into pending register.
REQ-008 SHALL have port data  in  4*NUM_DIG  hex nibbles; nibble i drives digit i, where digit 0 is rightmost.
REQ-009 SHALL have port dp_mask  in  NUM_DIG  per-digit decimal point, 1=lit.
REQ-010 SHALL have port blink_mask  in  NUM_DIG  per-digit blink request.
REQ-011 SHALL have port blank_lz  in  1  leading-zero blanking enable, sampled live.
REQ-012 SHALL have port seg_sel  out  NUM_DIG  digit select, active-low, one-hot-zero.
REQ-013 SHALL have port seg_led  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIG-1 to digit 0.

Function
REQ-015 SHALL free-run a prescaler 0..CLK_DIV-1 and assert an internal tick in the cycle where the count is CLK_DIV-1.
REQ-016 SHALL advance digit index idx on each tick, wrapping from NUM_DIG-1 to 0; frame_done SHALL pulse in the cycle after the wrapping tick.
REQ-017 seg_sel and seg_led SHALL be registered and reflect the new idx exactly 1 cycle after the tick.
REQ-018 On load, the pending register SHALL capture its inputs; pending SHALL transfer to the active register only on a wrapping tick. Back-to-back loads SHALL retain the last load (no tearing within a frame).
REQ-019 load coincident with a wrapping tick SHALL display the prior pending value this frame and the new value from the next frame.
REQ-020 SHALL decode hex 0..F onto standard 7-segment patterns; '0'=0xC0, '1'=0xF9, '2'=0xA4, '6'=0x82, '8'=0x80, 'F'=0x8E (dp off).
REQ-021 With blank_lz=1, digits above the most significant nonzero nibble SHALL be blanked (seg_sel bit high, seg_led=0xFF); digit 0 SHALL never be blanked. A blanked digit's dp SHALL also be off.
REQ-022 dp_mask bit idx=1 SHALL clear seg_led[7] for that digit.
REQ-023 en=0 SHALL drive seg_sel all-ones and seg_led=0xFF from the next cycle; prescaler, idx and frame_done SHALL keep running.

Reset
REQ-024 Reset SHALL set seg_sel all-ones, seg_led=0xFF, frame_done=0, prescaler=0, idx=0, pending and active registers=0, and blink phase=on.
REQ-025 Reset asserted mid-frame SHALL take effect on the next edge; scanning SHALL resume at idx 0 after the reset is released.

Configuration
REQ-026 With macro SEG_BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_FRAMES frames; during the off phase, digits whose active blink_mask bit is set SHALL be blanked.
REQ-027 Without SEG_BLINK_EN, blink_mask SHALL be ignored and no blink counter SHALL be synthesised.

Structure
REQ-028 The shared package seg_pkg SHALL hold the segment-code constants (SEG_OFF=8'hFF and the hex glyph table) and the digit-index width function.
REQ-029 Hex-to-segment decode SHALL be a separate combinational sub-module seg_hex_dec (4-bit in, 7-bit active-low out).

Verification (NUM_DIG=6, CLK_DIV=4, BLINK_FRAMES=2)
REQ-030 Assert reset -> seg_sel=6'h3F, seg_led=8'hFF, frame_done=0; release -> first tick at cycle 4, seg_sel=6'h3E one cycle later.
REQ-031 load data=24'h123456, dp_mask=0, then wait one frame -> digit 0 shows 0x82 with seg_sel=6'h3E, and digit 5 shows 0xF9 with seg_sel=6'h1F; frame_done pulses every 24 cycles.
REQ-032 data=24'h000120, blank_lz=1 -> digits 5..3 off, digit 2 shows 0xF9, digit 1 shows 0xA4, digit 0 shows 0xC0; data=0 -> only digit 0 shows 0xC0.
REQ-033 load 24'h888888 at idx 2 mid-frame -> digits 3..5 still show the old value; the next frame shows 0x80 on all digits; dp_mask=6'b000100 -> digit 2 shows 0x00.
REQ-034 With SEG_BLINK_EN, blink_mask=6'b000001 -> digit 0 lit for 2 frames, then off for 2 frames, repeating; en=0 -> all off next cycle while frame_done continues.
REQ-035 Assert reset at idx 3 for 1 cycle -> outputs go to reset values next edge; the scan restarts at idx 0 and the active register reads 0.
